alu_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit ALU. It accepts operations from two independent requesters (port 0: execute stage, port 1: branch/address unit) over valid/ready handshakes and grants the ALU round-robin. It registers operands, drives the ALU operand and control inputs for one cycle, captures the result and zero flag, and returns them to the granted requester over a valid/ready response handshake. One operation is in flight at a time.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 18 +
 rtl/alu_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, legality check and the
// arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {ALU_AND, ALU_OR, ALU_ADD,
                          ALU_SUB, ALU_SLT, ALU_NOR};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on a tie the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters,
// one operation in flight, registered response per port.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [3:0]      req_op0,
    input  logic [3:0]      req_op1,
    input  logic [XLEN-1:0] req_a0,
    input  logic [XLEN-1:0] req_b0,
    input  logic [XLEN-1:0] req_a1,
    input  logic [XLEN-1:0] req_b1,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            rsp_err,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result
);

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            gnt_q, gnt_d;
    logic            last_q, last_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;

    logic [1:0]      pick;
    logic [3:0]      sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;

    rr_arb2 u_arb (
        .valid_i (req_valid),
        .last_i  (last_q),
        .grant_o (pick)
    );

    assign sel_op = pick[1] ? req_op1 : req_op0;
    assign sel_a  = pick[1] ? req_a1  : req_a0;
    assign sel_b  = pick[1] ? req_b1  : req_b0;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        zero_d    = zero_q;
        err_d     = err_q;
        req_ready = 2'b00;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = pick;
                if (|pick) begin
                    gnt_d  = pick[1];
                    last_d = pick[1];
                    op_d   = sel_op;
                    a_d    = sel_a;
                    b_d    = sel_b;
                    if (is_legal_op(sel_op)) begin
                        err_d   = 1'b0;
                        state_d = ST_EXEC;
                    end else begin
                        // Illegal code bypasses the ALU entirely
                        err_d   = 1'b1;
                        res_d   = '0;
                        zero_d  = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                res_d   = alu_result;
                zero_d  = (alu_result == '0);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[gnt_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) req_ready = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= ALU_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP) ? {gnt_q, ~gnt_q} : 2'b00;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign alu_a      = (state_q == ST_EXEC) ? a_q  : '0;
    assign alu_b      = (state_q == ST_EXEC) ? b_q  : '0;
    assign alu_ctrl   = (state_q == ST_EXEC) ? op_q : ALU_IDLE;

endmodule
